cond_exec_sequencer: RTL

Per-instruction conditional-execution controller for the ARM datapath. It owns the architectural flag register {C,N,V,Z} and accepts one instruction at a time. It evaluates the IR[31:28] condition field against the current flags, then either launches the datapath and waits for completion or retires the instruction as skipped. On completion it commits results and updates the flags when the instruction sets them.

---
 rtl/cond_exec_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cond_exec_sequencer.sv
// Conditional-execution controller: owns the {C,N,V,Z} flag register, evaluates the
// ARM condition field of each accepted instruction, then runs, skips or aborts it.
module cond_exec_sequencer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             IR_Valid,
   input  logic [31:0]      IR,
   output logic             Ready,
   input  logic             Exec_Done,
   input  logic [3:0]       ALU_Flags,
   input  logic             Flags_Wr,
   input  logic [3:0]       Flags_In,
   output logic [3:0]       Flags,
   output logic             Exec_En,
   output logic             Commit,
   output logic             Skipped,
   output logic             Abort,
   output logic [CNT_W-1:0] Exec_Count,
   output logic [CNT_W-1:0] Skip_Count,
   output logic [CNT_W-1:0] Abort_Count,
   output logic [2:0]       Dbg_State
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_EVAL   = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
   localparam logic [2:0] S_SKIP   = 3'd4;
   localparam logic [2:0] S_ABORT  = 3'd5;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

   // Handshake: an instruction is taken on any rising edge where IR_Valid && Ready;
   // Ready is high only in IDLE, and IR is ignored whenever Ready is low.

   logic [2:0]       state_q, state_d;
   logic [3:0]       flags_q, flags_d;
   logic [3:0]       cond_q, cond_d;
   logic             s_q, s_d;
   logic [3:0]       alu_q, alu_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
   logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
   logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;
   logic             unused_ir;

   assign unused_ir = ^{IR[27:21], IR[19:0]};

   // Flag order is {C,N,V,Z}.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic c, n, v, z;
      c = f[3];
      n = f[2];
      v = f[1];
      z = f[0];
      case (cond)
         4'h0:    cond_pass = z;
         4'h1:    cond_pass = !z;
         4'h2:    cond_pass = c;
         4'h3:    cond_pass = !c;
         4'h4:    cond_pass = n;
         4'h5:    cond_pass = !n;
         4'h6:    cond_pass = v;
         4'h7:    cond_pass = !v;
         4'h8:    cond_pass = c & !z;
         4'h9:    cond_pass = !c | z;
         4'hA:    cond_pass = (n == v);
         4'hB:    cond_pass = (n != v);
         4'hC:    cond_pass = !z & (n == v);
         4'hD:    cond_pass = z | (n != v);
         4'hE:    cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      flags_d     = flags_q;
      cond_d      = cond_q;
      s_d         = s_q;
      alu_d       = alu_q;
      cnt_d       = cnt_q;
      exec_cnt_d  = exec_cnt_q;
      skip_cnt_d  = skip_cnt_q;
      abort_cnt_d = abort_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (Flags_Wr) flags_d = Flags_In;
            if (IR_Valid) begin
               cond_d  = IR[31:28];
               s_d     = IR[20];
               state_d = S_EVAL;
            end
         end
         S_EVAL: begin
            cnt_d   = '0;
            state_d = cond_pass(cond_q, flags_q) ? S_EXEC : S_SKIP;
         end
         S_EXEC: begin
            // Completion takes priority over a timeout in the same cycle.
            if (Exec_Done) begin
               alu_d   = ALU_Flags;
               state_d = S_COMMIT;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ABORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_COMMIT: begin
            if (s_q) flags_d = alu_q;
            exec_cnt_d = exec_cnt_q + 1'b1;
            state_d    = S_IDLE;
         end
         S_SKIP: begin
            skip_cnt_d = skip_cnt_q + 1'b1;
            state_d    = S_IDLE;
         end
         S_ABORT: begin
            abort_cnt_d = abort_cnt_q + 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         flags_q     <= '0;
         cond_q      <= '0;
         s_q         <= 1'b0;
         alu_q       <= '0;
         cnt_q       <= '0;
         exec_cnt_q  <= '0;
         skip_cnt_q  <= '0;
         abort_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flags_q     <= flags_d;
         cond_q      <= cond_d;
         s_q         <= s_d;
         alu_q       <= alu_d;
         cnt_q       <= cnt_d;
         exec_cnt_q  <= exec_cnt_d;
         skip_cnt_q  <= skip_cnt_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign Ready       = (state_q == S_IDLE);
   assign Exec_En     = (state_q == S_EXEC) && (cnt_q == '0);
   assign Commit      = (state_q == S_COMMIT);
   assign Skipped     = (state_q == S_SKIP);
   assign Abort       = (state_q == S_ABORT);
   assign Flags       = flags_q;
   assign Exec_Count  = exec_cnt_q;
   assign Skip_Count  = skip_cnt_q;
   assign Abort_Count = abort_cnt_q;
   assign Dbg_State   = state_q;

endmodule
